sd_protocol_monitor: RTL and testbench

SD_PROTOCOL_MONITOR -- requirements
Module: sd_protocol_monitor

---
 rtl/sd_protocol_monitor_if.sv | 36 +++
 rtl/sd_protocol_monitor.sv | 149 ++++++++++++++
 tb/tb_sd_protocol_monitor.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/sd_protocol_monitor_if.sv
// Bundle of monitored srdy/drdy channels plus the monitor's error and statistics outputs.
// The master modport drives stimulus; the slave modport is the monitor's view.
interface sd_protocol_monitor_if #(
    parameter int width     = 8,
    parameter int channels  = 2,
    parameter int cnt_width = 16
);
    localparam int chan_w = (channels > 1) ? $clog2(channels) : 1;

    logic [channels-1:0]           srdy;
    logic [channels-1:0]           drdy;
    logic [channels*width-1:0]     data;
    logic                          clear;

    logic [channels-1:0]           err_drop;
    logic [channels-1:0]           err_hold;
    logic [channels-1:0]           err_stall;
    logic                          err_any;
    logic                          first_valid;
    logic [chan_w-1:0]             first_chan;
    logic [1:0]                    first_code;
    logic [cnt_width-1:0]          first_time;
    logic [channels*cnt_width-1:0] xfer_count;

    modport master (
        output srdy, drdy, data, clear,
        input  err_drop, err_hold, err_stall, err_any,
        input  first_valid, first_chan, first_code, first_time, xfer_count
    );

    modport slave (
        input  srdy, drdy, data, clear,
        output err_drop, err_hold, err_stall, err_any,
        output first_valid, first_chan, first_code, first_time, xfer_count
    );
endinterface

// File: rtl/sd_protocol_monitor.sv
// Passive checker for srdy/drdy channels: flags drops, data changes and long stalls while a
// transfer is pending, records the first error, and counts transfers per channel.
module sd_protocol_monitor #(
    parameter int width     = 8,
    parameter int channels  = 2,
    parameter int max_stall = 3,
    parameter int cnt_width = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    sd_protocol_monitor_if.slave   mon
);
    localparam int chan_w = (channels > 1) ? $clog2(channels) : 1;
    localparam logic [7:0]           stall_max = 8'(max_stall);
    localparam logic [cnt_width-1:0] cnt_max   = '1;

    logic [cnt_width-1:0] ts_q;

    logic                 pend_q  [channels];
    logic [width-1:0]     data_q  [channels];
    logic [7:0]           stall_q [channels];
    logic [7:0]           stall_d [channels];
    logic [cnt_width-1:0] xfer_q  [channels];
    logic [cnt_width-1:0] xfer_d  [channels];

    logic [channels-1:0]  det_drop;
    logic [channels-1:0]  det_hold;
    logic [channels-1:0]  det_stall;

    logic [channels-1:0]  err_drop_q, err_drop_d;
    logic [channels-1:0]  err_hold_q, err_hold_d;
    logic [channels-1:0]  err_stall_q, err_stall_d;
    logic                 err_any_q, err_any_d;

    logic                 first_valid_q, first_valid_d;
    logic [chan_w-1:0]    first_chan_q, first_chan_d;
    logic [1:0]           first_code_q, first_code_d;
    logic [cnt_width-1:0] first_time_q, first_time_d;

    logic                 win_found;
    logic [chan_w-1:0]    win_chan;
    logic [1:0]           win_code;

    generate
        for (genvar gi = 0; gi < channels; gi++) begin : g_chan
            logic [width-1:0]     din;
            logic                 pending;
            logic                 xfer;
            logic [cnt_width-1:0] xfer_base;

            assign din     = mon.data[gi*width +: width];
            assign pending = mon.srdy[gi] & ~mon.drdy[gi];
            assign xfer    = mon.srdy[gi] & mon.drdy[gi];

            assign det_drop[gi]  = pend_q[gi] & ~mon.srdy[gi];
            assign det_hold[gi]  = pend_q[gi] & (din != data_q[gi]);
            assign det_stall[gi] = pending & (stall_q[gi] == stall_max);

            assign stall_d[gi] = !pending                   ? 8'd0 :
                                 (stall_q[gi] == stall_max) ? stall_q[gi] :
                                                              stall_q[gi] + 8'd1;

            // Clear and a same-cycle transfer combine: the count restarts at 1.
            assign xfer_base  = mon.clear ? '0 : xfer_q[gi];
            assign xfer_d[gi] = (xfer && (xfer_base != cnt_max)) ? xfer_base + 1'b1 : xfer_base;

            always_ff @(posedge clk) begin
                if (reset) begin
                    pend_q[gi]  <= 1'b0;
                    data_q[gi]  <= '0;
                    stall_q[gi] <= 8'd0;
                    xfer_q[gi]  <= '0;
                end else begin
                    pend_q[gi]  <= pending;
                    data_q[gi]  <= din;
                    stall_q[gi] <= stall_d[gi];
                    xfer_q[gi]  <= xfer_d[gi];
                end
            end

            assign mon.xfer_count[gi*cnt_width +: cnt_width] = xfer_q[gi];
        end
    endgenerate

    // Descending scan so the lowest-numbered detecting channel is the last one written.
    always_comb begin
        win_found = 1'b0;
        win_chan  = '0;
        win_code  = 2'd0;
        for (int i = channels - 1; i >= 0; i--) begin
            if (det_drop[i] || det_hold[i] || det_stall[i]) begin
                win_found = 1'b1;
                win_chan  = chan_w'(i);
                win_code  = det_drop[i] ? 2'd1 : (det_hold[i] ? 2'd2 : 2'd3);
            end
        end
    end

    always_comb begin
        err_drop_d  = (mon.clear ? '0 : err_drop_q)  | det_drop;
        err_hold_d  = (mon.clear ? '0 : err_hold_q)  | det_hold;
        err_stall_d = (mon.clear ? '0 : err_stall_q) | det_stall;
        err_any_d   = |{err_drop_d, err_hold_d, err_stall_d};

        first_valid_d = mon.clear ? 1'b0 : first_valid_q;
        first_chan_d  = mon.clear ? '0   : first_chan_q;
        first_code_d  = mon.clear ? 2'd0 : first_code_q;
        first_time_d  = mon.clear ? '0   : first_time_q;
        if (!first_valid_d && win_found) begin
            first_valid_d = 1'b1;
            first_chan_d  = win_chan;
            first_code_d  = win_code;
            first_time_d  = ts_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ts_q          <= '0;
            err_drop_q    <= '0;
            err_hold_q    <= '0;
            err_stall_q   <= '0;
            err_any_q     <= 1'b0;
            first_valid_q <= 1'b0;
            first_chan_q  <= '0;
            first_code_q  <= 2'd0;
            first_time_q  <= '0;
        end else begin
            ts_q          <= ts_q + 1'b1;
            err_drop_q    <= err_drop_d;
            err_hold_q    <= err_hold_d;
            err_stall_q   <= err_stall_d;
            err_any_q     <= err_any_d;
            first_valid_q <= first_valid_d;
            first_chan_q  <= first_chan_d;
            first_code_q  <= first_code_d;
            first_time_q  <= first_time_d;
        end
    end

    assign mon.err_drop    = err_drop_q;
    assign mon.err_hold    = err_hold_q;
    assign mon.err_stall   = err_stall_q;
    assign mon.err_any     = err_any_q;
    assign mon.first_valid = first_valid_q;
    assign mon.first_chan  = first_chan_q;
    assign mon.first_code  = first_code_q;
    assign mon.first_time  = first_time_q;
endmodule

// File: tb/tb_sd_protocol_monitor.sv
// Directed bench for sd_protocol_monitor with 2 channels, max_stall=3 and 4-bit counters.
module tb_sd_protocol_monitor;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] tb_ts = 4'd0;
    logic [3:0] exp_t;
    int n_checks = 0;
    int n_fail = 0;

    sd_protocol_monitor_if #(.width(8), .channels(2), .cnt_width(4)) bus ();

    sd_protocol_monitor #(
        .width(8), .channels(2), .max_stall(3), .cnt_width(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mon(bus)
    );

    always #5 clk = ~clk;

    // Expected timestamp: zero on a reset edge, otherwise +1 per cycle modulo 16.
    always @(posedge clk) tb_ts <= reset ? 4'd0 : tb_ts + 4'd1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [1:0] s, input logic [1:0] d,
                          input logic [7:0] d0, input logic [7:0] d1, input logic clr);
        bus.srdy  = s;
        bus.drdy  = d;
        bus.data  = {d1, d0};
        bus.clear = clr;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        set_in(2'b00, 2'b00, 8'h00, 8'h00, 1'b0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_err_any", 32'(bus.err_any), 32'd0);
        chk("rst_err_flags", 32'({bus.err_drop, bus.err_hold, bus.err_stall}), 32'd0);
        chk("rst_first_valid", 32'(bus.first_valid), 32'd0);
        chk("rst_xfer", 32'(bus.xfer_count), 32'd0);

        // Drop on ch0
        set_in(2'b01, 2'b00, 8'h00, 8'h00, 1'b0);
        tick();
        set_in(2'b00, 2'b00, 8'h00, 8'h00, 1'b0);
        exp_t = tb_ts;
        tick();
        chk("drop_err_drop", 32'(bus.err_drop), 32'h1);
        chk("drop_err_hold", 32'(bus.err_hold), 32'h0);
        chk("drop_err_any", 32'(bus.err_any), 32'h1);
        chk("drop_first_code", 32'(bus.first_code), 32'd1);
        chk("drop_first_chan", 32'(bus.first_chan), 32'd0);
        chk("drop_first_time", 32'(bus.first_time), 32'(exp_t));

        set_in(2'b00, 2'b00, 8'h00, 8'h00, 1'b1);
        tick();
        bus.clear = 1'b0;
        chk("clr_err_any", 32'(bus.err_any), 32'd0);
        chk("clr_first", 32'({bus.first_valid, bus.first_code}), 32'd0);

        // Hold error on ch1 with transfer
        set_in(2'b10, 2'b00, 8'h00, 8'h5A, 1'b0);
        tick();
        set_in(2'b10, 2'b10, 8'h00, 8'hA5, 1'b0);
        tick();
        chk("hold_err_hold", 32'(bus.err_hold), 32'h2);
        chk("hold_err_drop", 32'(bus.err_drop), 32'h0);
        chk("hold_xfer1", 32'(bus.xfer_count[7:4]), 32'd1);
        chk("hold_first", 32'({bus.first_chan, bus.first_code}), 32'({1'b1, 2'd2}));
        set_in(2'b00, 2'b00, 8'h00, 8'hA5, 1'b1);
        tick();
        bus.clear = 1'b0;

        // Stall on ch0 for 4 cycles
        set_in(2'b01, 2'b00, 8'h00, 8'hA5, 1'b0);
        tick();
        tick();
        tick();
        chk("stall3_err_stall", 32'(bus.err_stall), 32'h0);
        exp_t = tb_ts;
        tick();
        chk("stall4_err_stall", 32'(bus.err_stall), 32'h1);
        chk("stall4_first_code", 32'(bus.first_code), 32'd3);
        chk("stall4_first_time", 32'(bus.first_time), 32'(exp_t));
        chk("stall4_err_drop", 32'(bus.err_drop), 32'h0);
        set_in(2'b01, 2'b01, 8'h00, 8'hA5, 1'b0);
        tick();
        chk("stall_release_xfer0", 32'(bus.xfer_count[3:0]), 32'd1);
        chk("stall_release_drop", 32'(bus.err_drop), 32'h0);
        set_in(2'b00, 2'b00, 8'h00, 8'hA5, 1'b1);
        tick();
        bus.clear = 1'b0;

        // Drop on ch1 and hold on ch0 together
        set_in(2'b11, 2'b00, 8'h11, 8'h22, 1'b0);
        tick();
        set_in(2'b01, 2'b01, 8'h33, 8'h22, 1'b0);
        tick();
        chk("multi_err_drop", 32'(bus.err_drop), 32'h2);
        chk("multi_err_hold", 32'(bus.err_hold), 32'h1);
        chk("multi_first", 32'({bus.first_chan, bus.first_code}), 32'({1'b0, 2'd2}));
        chk("multi_xfer0", 32'(bus.xfer_count[3:0]), 32'd1);

        // Clear in the same cycle as a new drop: the new error survives
        set_in(2'b01, 2'b00, 8'h33, 8'h22, 1'b0);
        tick();
        set_in(2'b00, 2'b00, 8'h33, 8'h22, 1'b1);
        exp_t = tb_ts;
        tick();
        bus.clear = 1'b0;
        chk("clrset_err_drop", 32'(bus.err_drop), 32'h1);
        chk("clrset_err_hold", 32'(bus.err_hold), 32'h0);
        chk("clrset_first", 32'({bus.first_valid, bus.first_chan, bus.first_code}),
            32'({1'b1, 1'b0, 2'd1}));
        chk("clrset_first_time", 32'(bus.first_time), 32'(exp_t));
        chk("clrset_xfer0", 32'(bus.xfer_count[3:0]), 32'd0);
        set_in(2'b00, 2'b00, 8'h33, 8'h22, 1'b1);
        tick();
        bus.clear = 1'b0;

        // Transfer counter saturation, then clear with a transfer
        set_in(2'b01, 2'b01, 8'h33, 8'h22, 1'b0);
        for (int k = 0; k < 20; k++) tick();
        chk("sat_xfer0", 32'(bus.xfer_count[3:0]), 32'd15);
        chk("sat_xfer1", 32'(bus.xfer_count[7:4]), 32'd0);
        chk("sat_err_any", 32'(bus.err_any), 32'd0);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        chk("clrxfer_xfer0", 32'(bus.xfer_count[3:0]), 32'd1);
        set_in(2'b00, 2'b00, 8'h33, 8'h22, 1'b0);
        tick();

        // Reset mid-stall discards stall history
        set_in(2'b01, 2'b00, 8'h33, 8'h22, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_first_time_base", 32'(tb_ts), 32'd0);
        tick();
        tick();
        tick();
        chk("rststall3_err_stall", 32'(bus.err_stall), 32'h0);
        chk("rststall3_err_any", 32'(bus.err_any), 32'h0);
        exp_t = tb_ts;
        tick();
        chk("rststall4_err_stall", 32'(bus.err_stall), 32'h1);
        chk("rststall4_first_time", 32'(bus.first_time), 32'(exp_t));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
